if_fetch: RTL and testbench

Instruction fetch unit on the consumer side of the PC register. It reads the current `pc` from the PC register and fetches the instruction from the shared instruction/data SRAM. Fetched instructions, tagged with their address, go into a 2-entry buffer for the ID stage. It drives the active-low `pc_write` strobe back to the PC register, so the PC advances only when a fetch has completed or a jump is taken.

---
 rtl/if_fetch_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/if_fetch.sv | 129 ++++++++++++
 tb/tb_if_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared widths, reset vector, fetch FSM encoding and the
//            instruction-buffer entry type used by the fetch unit.
// Revision : 1.0  initial release
// ============================================================================
package if_fetch_pkg;

    // Datapath widths of the shared instruction/data SRAM.
    localparam int ADDR_W  = 18;
    localparam int INSTR_W = 16;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    // Wait-state counter width; covers WAIT_CYCLES up to 7.
    localparam int CNT_W = 3;

    // Program start address, shared with the PC register.
    localparam logic [ADDR_W-1:0] RESET_VECTOR = 18'h08000;

    // Fetch FSM encoding.
    localparam logic [0:0] S_ISSUE = 1'b0;
    localparam logic [0:0] S_WAIT  = 1'b1;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Two-entry first-word-fall-through buffer between instruction
//            fetch and decode. Supports push/pop in the same cycle and a
//            flush that overrides both.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop_en;
    logic         w_push_en;

    // A pop on an empty buffer is dropped; a push is only taken when there
    // is room (or room is being made by a simultaneous pop).
    always_comb begin
        w_pop_en  = i_pop && (r_count != 2'd0);
        w_push_en = i_push && ((r_count != 2'd2) || w_pop_en);
    end

    // Storage, pointers and occupancy; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_en) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is presented as zero while empty so no stale word is visible.
    always_comb begin
        o_count = r_count;
        o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction fetch unit. Issues one SRAM read at a time for the
//            current PC, waits WAIT_CYCLES, pushes the word into a 2-entry
//            buffer for decode and strobes pc_write (active-low) so the PC
//            register advances on completed fetches and jumps only.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int WAIT_CYCLES = 1   // legal range 1..7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               pc_jump,
    output logic               pc_write,
    input  logic               mem_busy,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic               sram_oe_n,
    input  logic [INSTR_W-1:0] sram_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_sram_oe_n;

    logic              w_flush;
    logic              w_abort;
    logic              w_issue;
    logic              w_capture;
    logic [1:0]        w_count;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    // Control decode. A jump (pc_jump low) flushes everything; MEM owning
    // the bus kills an in-flight read, and either one suppresses capture.
    always_comb begin
        w_flush   = !pc_jump;
        w_abort   = (r_state == S_WAIT) && mem_busy;
        w_issue   = (r_state == S_ISSUE) && !mem_busy && (w_count != 2'd2) && pc_jump;
        w_capture = (r_state == S_WAIT) && (r_cnt == c_cnt_one) && !mem_busy && pc_jump;
    end

    // PC advances on the capture edge or loads the target on a jump edge;
    // held while reset is asserted.
    always_comb begin
        if (!rst) begin
            pc_write = 1'b1;
        end else begin
            pc_write = !(w_capture || w_flush);
        end
    end

    // Fetch FSM: issue a registered read, count wait states, then capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_ISSUE;
            r_cnt       <= '0;
            r_sram_addr <= '0;
            r_sram_oe_n <= 1'b1;
        end else if (w_flush || w_abort) begin
            // The read is abandoned; the unchanged pc is re-fetched later.
            r_state     <= S_ISSUE;
            r_cnt       <= '0;
            r_sram_oe_n <= 1'b1;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (w_issue) begin
                        r_sram_addr <= pc;
                        r_sram_oe_n <= 1'b0;
                        r_cnt       <= c_wait_load;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (w_capture) begin
                        r_sram_oe_n <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                default: begin
                    r_state     <= S_ISSUE;
                    r_sram_oe_n <= 1'b1;
                end
            endcase
        end
    end

    // Captured word is tagged with the address it was read from.
    always_comb begin
        w_push_entry.instr = sram_data;
        w_push_entry.pc    = r_sram_addr;
    end

    fetch_fifo u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_capture),
        .i_push_data (w_push_entry),
        .i_pop       (instr_ready),
        .i_flush     (w_flush),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    // Registered SRAM controls and buffer head to the ports.
    always_comb begin
        sram_addr   = r_sram_addr;
        sram_oe_n   = r_sram_oe_n;
        instr       = w_head.instr;
        instr_pc    = w_head.pc;
        instr_valid = (w_count != 2'd0);
    end

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Directed, table-driven bench for if_fetch. One instance runs
//            with one wait state through free-run, bus abort, back-pressure
//            and jump; a second instance with three wait states is reset
//            in the middle of a read.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [ADDR_W-1:0] JUMP_TARGET = 18'h08100;

    logic clk;
    logic rst;
    logic pc_jump;
    logic mem_busy;
    logic instr_ready;

    logic [ADDR_W-1:0]  pc1, sram_addr1, instr_pc1;
    logic [INSTR_W-1:0] sram_data1, instr1;
    logic               pc_write1, sram_oe_n1, instr_valid1;

    logic [ADDR_W-1:0]  pc3, sram_addr3, instr_pc3;
    logic [INSTR_W-1:0] sram_data3, instr3;
    logic               pc_write3, sram_oe_n3, instr_valid3;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic               mb;
        logic               rdy;
        logic               jmp;
        logic               pw;
        logic               oe;
        logic [ADDR_W-1:0]  addr;
        logic               valid;
        logic [INSTR_W-1:0] ins;
        logic [ADDR_W-1:0]  ipc;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic logic [INSTR_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        case (a)
            18'h08000: sram_word = 16'h1111;
            18'h08001: sram_word = 16'h2222;
            18'h08002: sram_word = 16'h3333;
            18'h08003: sram_word = 16'h4444;
            18'h08004: sram_word = 16'h5555;
            18'h08100: sram_word = 16'hAAAA;
            18'h08101: sram_word = 16'hBBBB;
            default:   sram_word = 16'hEEEE;
        endcase
    endfunction

    function automatic vec_t mk(input logic mb, input logic rdy, input logic jmp,
                                input logic pw, input logic oe, input logic [ADDR_W-1:0] addr,
                                input logic valid, input logic [INSTR_W-1:0] ins,
                                input logic [ADDR_W-1:0] ipc);
        mk = '{mb, rdy, jmp, pw, oe, addr, valid, ins, ipc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic check_dut3(input string tag, input logic pw, input logic oe,
                              input logic [ADDR_W-1:0] addr, input logic valid,
                              input logic [INSTR_W-1:0] ins, input logic [ADDR_W-1:0] ipc);
        check({tag, " pc_write"},    32'(pc_write3),    32'(pw));
        check({tag, " sram_oe_n"},   32'(sram_oe_n3),   32'(oe));
        check({tag, " sram_addr"},   32'(sram_addr3),   32'(addr));
        check({tag, " instr_valid"}, 32'(instr_valid3), 32'(valid));
        check({tag, " instr"},       32'(instr3),       32'(ins));
        check({tag, " instr_pc"},    32'(instr_pc3),    32'(ipc));
    endtask

    // PC register models: advance on capture, load target on jump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc1 <= RESET_VECTOR;
            pc3 <= RESET_VECTOR;
        end else begin
            if (!pc_write1) pc1 <= pc_jump ? pc1 + 18'd1 : JUMP_TARGET;
            if (!pc_write3) pc3 <= pc_jump ? pc3 + 18'd1 : JUMP_TARGET;
        end
    end

    assign sram_data1 = sram_oe_n1 ? 16'h0000 : sram_word(sram_addr1);
    assign sram_data3 = sram_oe_n3 ? 16'h0000 : sram_word(sram_addr3);

    if_fetch #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .pc(pc1), .pc_jump(pc_jump), .pc_write(pc_write1),
        .mem_busy(mem_busy), .sram_addr(sram_addr1), .sram_oe_n(sram_oe_n1),
        .sram_data(sram_data1), .instr(instr1), .instr_pc(instr_pc1),
        .instr_valid(instr_valid1), .instr_ready(instr_ready)
    );

    if_fetch #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .pc(pc3), .pc_jump(pc_jump), .pc_write(pc_write3),
        .mem_busy(mem_busy), .sram_addr(sram_addr3), .sram_oe_n(sram_oe_n3),
        .sram_data(sram_data3), .instr(instr3), .instr_pc(instr_pc3),
        .instr_valid(instr_valid3), .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        // Cycle table for the one-wait-state instance. Inputs are applied in
        // the cycle, outputs are those visible during that same cycle.
        //               mb rdy jmp pw oe addr        vld instr     instr_pc
        vecs[0]  = mk(0, 1, 1, 1, 1, 18'h00000, 0, 16'h0000, 18'h00000); // issue 8000
        vecs[1]  = mk(0, 1, 1, 0, 0, 18'h08000, 0, 16'h0000, 18'h00000); // capture
        vecs[2]  = mk(0, 1, 1, 1, 1, 18'h08000, 1, 16'h1111, 18'h08000); // issue 8001
        vecs[3]  = mk(0, 1, 1, 0, 0, 18'h08001, 0, 16'h0000, 18'h00000);
        vecs[4]  = mk(0, 1, 1, 1, 1, 18'h08001, 1, 16'h2222, 18'h08001); // issue 8002
        vecs[5]  = mk(1, 1, 1, 1, 0, 18'h08002, 0, 16'h0000, 18'h00000); // abort
        vecs[6]  = mk(1, 1, 1, 1, 1, 18'h08002, 0, 16'h0000, 18'h00000); // bus held
        vecs[7]  = mk(0, 1, 1, 1, 1, 18'h08002, 0, 16'h0000, 18'h00000); // re-issue 8002
        vecs[8]  = mk(0, 1, 1, 0, 0, 18'h08002, 0, 16'h0000, 18'h00000);
        vecs[9]  = mk(0, 0, 1, 1, 1, 18'h08002, 1, 16'h3333, 18'h08002); // issue 8003
        vecs[10] = mk(0, 0, 1, 0, 0, 18'h08003, 1, 16'h3333, 18'h08002); // fills buffer
        vecs[11] = mk(0, 0, 1, 1, 1, 18'h08003, 1, 16'h3333, 18'h08002); // full: no issue
        vecs[12] = mk(0, 0, 1, 1, 1, 18'h08003, 1, 16'h3333, 18'h08002);
        vecs[13] = mk(0, 1, 1, 1, 1, 18'h08003, 1, 16'h3333, 18'h08002); // pop 3333
        vecs[14] = mk(0, 0, 1, 1, 1, 18'h08003, 1, 16'h4444, 18'h08003); // issue 8004
        vecs[15] = mk(0, 0, 0, 0, 0, 18'h08004, 1, 16'h4444, 18'h08003); // jump on capture
        vecs[16] = mk(0, 1, 1, 1, 1, 18'h08004, 0, 16'h0000, 18'h00000); // issue 8100
        vecs[17] = mk(0, 1, 1, 0, 0, 18'h08100, 0, 16'h0000, 18'h00000);
        vecs[18] = mk(0, 1, 1, 1, 1, 18'h08100, 1, 16'hAAAA, 18'h08100);
        vecs[19] = mk(0, 1, 1, 0, 0, 18'h08101, 0, 16'h0000, 18'h00000);
        vecs[20] = mk(0, 1, 1, 1, 1, 18'h08101, 1, 16'hBBBB, 18'h08101);

        rst         = 1'b0;
        pc_jump     = 1'b1;
        mem_busy    = 1'b0;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset pc_write",    32'(pc_write1),    32'd1);
        check("reset sram_oe_n",   32'(sram_oe_n1),   32'd1);
        check("reset sram_addr",   32'(sram_addr1),   32'd0);
        check("reset instr_valid", 32'(instr_valid1), 32'd0);
        check("reset instr",       32'(instr1),       32'd0);
        check("reset instr_pc",    32'(instr_pc1),    32'd0);
        pc_jump = 1'b0;
        #1;
        check("reset pc_write with jump low", 32'(pc_write1), 32'd1);
        @(negedge clk);
        pc_jump = 1'b1;
        rst     = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            mem_busy    = vecs[i].mb;
            instr_ready = vecs[i].rdy;
            pc_jump     = vecs[i].jmp;
            #1;
            check($sformatf("c%0d pc_write", i),    32'(pc_write1),    32'(vecs[i].pw));
            check($sformatf("c%0d sram_oe_n", i),   32'(sram_oe_n1),   32'(vecs[i].oe));
            check($sformatf("c%0d sram_addr", i),   32'(sram_addr1),   32'(vecs[i].addr));
            check($sformatf("c%0d instr_valid", i), 32'(instr_valid1), 32'(vecs[i].valid));
            check($sformatf("c%0d instr", i),       32'(instr1),       32'(vecs[i].ins));
            check($sformatf("c%0d instr_pc", i),    32'(instr_pc1),    32'(vecs[i].ipc));
            @(negedge clk);
        end

        // Three-wait-state instance: restart, then reset in the middle of a read.
        mem_busy    = 1'b0;
        instr_ready = 1'b1;
        pc_jump     = 1'b1;
        rst         = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);                                   // issue edge passed
        #1;
        check_dut3("w3 in-flight", 1'b1, 1'b0, 18'h08000, 1'b0, 16'h0000, 18'h00000);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_dut3("w3 async reset", 1'b1, 1'b1, 18'h00000, 1'b0, 16'h0000, 18'h00000);
        repeat (2) @(negedge clk);
        #1;
        check_dut3("w3 held reset", 1'b1, 1'b1, 18'h00000, 1'b0, 16'h0000, 18'h00000);
        rst = 1'b1;
        // Fresh read of 8000: issue, three wait cycles, visible afterwards.
        #1;
        check_dut3("w3 post0", 1'b1, 1'b1, 18'h00000, 1'b0, 16'h0000, 18'h00000);
        @(negedge clk);
        #1;
        check_dut3("w3 post1", 1'b1, 1'b0, 18'h08000, 1'b0, 16'h0000, 18'h00000);
        @(negedge clk);
        #1;
        check_dut3("w3 post2", 1'b1, 1'b0, 18'h08000, 1'b0, 16'h0000, 18'h00000);
        @(negedge clk);
        #1;
        check_dut3("w3 post3", 1'b0, 1'b0, 18'h08000, 1'b0, 16'h0000, 18'h00000);
        @(negedge clk);
        #1;
        check_dut3("w3 post4", 1'b1, 1'b1, 18'h08000, 1'b1, 16'h1111, 18'h08000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_if_fetch
`default_nettype wire
